// File: rtl/mult_err_accum.sv
// ---------------------------------------------------------------------------
// mult_err_accum
//
// Measures the error of an 8x8 approximate multiplier over a window of
// W = 2^N_LOG2 accepted samples. For every sample the exact product A*B is
// compared with the product R from the multiplier under test. The block
// accumulates the sum, the maximum and the count of non-zero absolute errors.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - begins a window when sampled high in IDLE
//   in_valid - A/B/R sample present
//   in_ready - sample accepted this cycle (decoded from registered state)
//   A, B     - unsigned operands given to the approximate multiplier
//   R        - approximate product returned by the multiplier under test
//   busy     - high while the window runs or drains
//   done     - one-cycle pulse; results are final
//   sum_ed   - sum of |A*B - R| over the window
//   max_ed   - maximum |A*B - R| in the window
//   err_cnt  - number of samples with R != A*B
// ---------------------------------------------------------------------------
module mult_err_accum #(
    parameter int N_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           A,
    input  logic [7:0]           B,
    input  logic [15:0]          R,
    output logic                 busy,
    output logic                 done,
    output logic [16+N_LOG2-1:0] sum_ed,
    output logic [15:0]          max_ed,
    output logic [N_LOG2:0]      err_cnt
);

    localparam int W  = 1 << N_LOG2;
    localparam int SW = 16 + N_LOG2;
    localparam int CW = N_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;        // accepted samples in current window
    logic          drain_2nd;  // set during the second DRAIN cycle
    logic          accept;
    logic          last_accept;
    logic          clear;

    // Pipeline stage 1: exact product and sampled R
    logic          v1;
    logic [15:0]   exact_q;
    logic [15:0]   r_q;
    // Pipeline stage 2: absolute error and mismatch flag
    logic          v2;
    logic [15:0]   ed_q;
    logic          mis_q;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (cnt == CW'(W - 1));
    assign clear       = (state == IDLE) && start;

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = (cnt < CW'(W));
                if (last_accept) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Two cycles cover stages e1 and e2 of the last sample.
                if (drain_2nd) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential blocks use non-blocking '<=' so every flop samples
    // values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_2nd <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_2nd <= (state == DRAIN) && !drain_2nd;
            if (clear) cnt <= '0;
            else if (accept) cnt <= cnt + 1'b1;
            v1 <= accept;
            v2 <= v1;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits v1/v2 qualify
    // them, so their contents after reset are never consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            exact_q <= 16'(A) * 16'(B);
            r_q     <= R;
        end
        if (v1) begin
            // Subtract the smaller from the larger so the result never wraps.
            ed_q  <= (exact_q >= r_q) ? (exact_q - r_q) : (r_q - exact_q);
            mis_q <= (exact_q != r_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (clear) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (v2) begin
            sum_ed  <= sum_ed + SW'(ed_q);
            if (ed_q > max_ed) max_ed <= ed_q;
            err_cnt <= err_cnt + CW'(mis_q);
        end
    end

endmodule

// File: tb/tb_mult_err_accum.sv
// ---------------------------------------------------------------------------
// tb_mult_err_accum
//
// Self-checking bench for mult_err_accum with N_LOG2 = 2 (four samples per
// window). Directed windows come from a table of samples with expected
// results; random windows are scored by an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mult_err_accum;

    localparam int N_LOG2 = 2;
    localparam int NS     = 1 << N_LOG2;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           a;
    logic [7:0]           b;
    logic [15:0]          r;
    logic                 busy;
    logic                 done;
    logic [16+N_LOG2-1:0] sum_ed;
    logic [15:0]          max_ed;
    logic [N_LOG2:0]      err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mult_err_accum #(.N_LOG2(N_LOG2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a),
        .B        (b),
        .R        (r),
        .busy     (busy),
        .done     (done),
        .sum_ed   (sum_ed),
        .max_ed   (max_ed),
        .err_cnt  (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [NS-1:0][7:0]  a;
        logic [NS-1:0][7:0]  b;
        logic [NS-1:0][15:0] r;
        logic [NS-1:0][1:0]  gap;      // idle cycles before each sample
        logic                chaos;    // start pulses + in_valid held past W
        logic [31:0]         exp_sum;
        logic [31:0]         exp_max;
        logic [31:0]         exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: error statistics straight from the definition.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        int s = 0, m = 0, c = 0;
        for (int i = 0; i < NS; i++) begin
            int d = int'(v.a[i]) * int'(v.b[i]) - int'(v.r[i]);
            if (d < 0) d = -d;
            s += d;
            if (d > m) m = d;
            if (d != 0) c++;
        end
        o.exp_sum = 32'(s);
        o.exp_max = 32'(m);
        o.exp_cnt = 32'(c);
        return o;
    endfunction

    // Runs one window; called at a negedge, returns at a negedge in IDLE.
    task automatic run_window(input string name, input vec_t v);
        int lat = 0;
        start = 1'b1;
        @(negedge clk);
        start = v.chaos;
        check({name, " busy_run"}, 32'(busy), 1);
        for (int i = 0; i < NS; i++) begin
            for (int g = 0; g < int'(v.gap[i]); g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            a = v.a[i];
            b = v.b[i];
            r = v.r[i];
            check({name, " in_ready_run"}, 32'(in_ready), 1);
            @(negedge clk);
        end
        // Extra samples offered after the window is full must be dropped.
        if (v.chaos) begin
            a = 8'd255;
            b = 8'd255;
            r = 16'd0;
        end else begin
            in_valid = 1'b0;
        end
        check({name, " in_ready_drain"}, 32'(in_ready), 0);
        check({name, " busy_drain"}, 32'(busy), 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check({name, " done_latency"}, 32'(lat), 2);
        check({name, " busy_done"}, 32'(busy), 0);
        check({name, " sum_ed"}, 32'(sum_ed), v.exp_sum);
        check({name, " max_ed"}, 32'(max_ed), v.exp_max);
        check({name, " err_cnt"}, 32'(err_cnt), v.exp_cnt);
        @(negedge clk);
        check({name, " done_pulse"}, 32'(done), 0);
        check({name, " sum_held"}, 32'(sum_ed), v.exp_sum);
        @(negedge clk);
        check({name, " idle_busy"}, 32'(busy), 0);
        check({name, " idle_done"}, 32'(done), 0);
        check({name, " err_held"}, 32'(err_cnt), v.exp_cnt);
    endtask

    vec_t vecs[4];

    initial begin
        vec_t rv;

        // Directed table: exact, worst case, gapped mix, start/valid chaos.
        vecs[0] = '0;
        vecs[0].a = {NS{8'd3}};
        vecs[0].b = {NS{8'd5}};
        vecs[0].r = {NS{16'd15}};

        vecs[1] = '0;
        vecs[1].a = {NS{8'd255}};
        vecs[1].b = {NS{8'd255}};
        vecs[1].r = {NS{16'd0}};
        vecs[1].exp_sum = 260100;
        vecs[1].exp_max = 65025;
        vecs[1].exp_cnt = 4;

        vecs[2] = '0;
        vecs[2].a   = {8'd15, 8'd0, 8'd10, 8'd10};
        vecs[2].b   = {8'd15, 8'd0, 8'd10, 8'd10};
        vecs[2].r   = {16'd225, 16'd0, 16'd104, 16'd96};
        vecs[2].gap = {2'd1, 2'd3, 2'd2, 2'd1};
        vecs[2].exp_sum = 8;
        vecs[2].exp_max = 4;
        vecs[2].exp_cnt = 2;

        vecs[3] = '0;
        vecs[3].a     = {8'd0, 8'd1, 8'd100, 8'd2};
        vecs[3].b     = {8'd7, 8'd1, 8'd200, 8'd3};
        vecs[3].r     = {16'd5, 16'd0, 16'd20000, 16'd7};
        vecs[3].gap   = {2'd0, 2'd1, 2'd0, 2'd2};
        vecs[3].chaos = 1'b1;
        vecs[3].exp_sum = 7;
        vecs[3].exp_max = 5;
        vecs[3].exp_cnt = 3;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        r        = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset sum_ed", 32'(sum_ed), 0);
        check("reset max_ed", 32'(max_ed), 0);
        check("reset err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_window($sformatf("vec%0d", i), vecs[i]);
        end

        // Abort mid-RUN: accumulate one error, then reset asynchronously.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        a = 8'd255;
        b = 8'd255;
        r = 16'd0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort partial sum", 32'(sum_ed), 65025);
        #1 rst = 1'b1;
        #1;
        check("abort async busy", 32'(busy), 0);
        check("abort async in_ready", 32'(in_ready), 0);
        check("abort async sum", 32'(sum_ed), 0);
        check("abort async max", 32'(max_ed), 0);
        check("abort async err", 32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort waits idle", 32'(busy), 0);
        run_window("post_abort", vecs[0]);

        // Random windows scored by the model.
        for (int n = 0; n < 20; n++) begin
            rv = '0;
            for (int i = 0; i < NS; i++) begin
                int mode;
                logic [15:0] ex;
                rv.a[i]   = 8'($urandom);
                rv.b[i]   = 8'($urandom);
                rv.gap[i] = 2'($urandom_range(0, 3));
                ex   = 16'(rv.a[i]) * 16'(rv.b[i]);
                mode = int'($urandom_range(0, 2));
                if (mode == 0) rv.r[i] = ex;
                else if (mode == 1) rv.r[i] = 16'($urandom);
                else rv.r[i] = ex ^ 16'($urandom_range(0, 7));
            end
            rv.chaos = (n % 5 == 4);
            rv = model(rv);
            run_window($sformatf("rand%0d", n), rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
